steed_lane_fifo: RTL and testbench

Parametrised width-converting, direction-switchable byte FIFO between the 16-bit IDE host datapath and an N-lane NAND datapath. It succeeds the single-lane host/NAND FIFO and adds configurable lane count, depth and thresholds, plus occupancy reporting, flush and sticky error flags. It sits between the steed control block and the NAND IO lanes; both sides run on the single core clock.

---
 rtl/steed_lane_fifo_pkg.sv | 18 +
 rtl/steed_lane_fifo_if.sv | 47 ++++
 rtl/steed_byte_ram.sv | 40 ++++
 rtl/steed_lane_fifo.sv | 169 ++++++++++++++++
 tb/tb_steed_lane_fifo.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/steed_lane_fifo_pkg.sv
// Shared types and default sizing for the steed lane FIFO slice.
package steed_lane_fifo_pkg;

    typedef enum logic {
        DIR_H2N = 1'b0,
        DIR_N2H = 1'b1
    } dir_e;

    localparam int unsigned DEF_HOST_W    = 16;
    localparam int unsigned DEF_LANE_W    = 8;
    localparam int unsigned DEF_NUM_LANES = 2;
    localparam int unsigned DEF_DEPTH     = 32;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/steed_lane_fifo_if.sv
// Host/NAND handshake, data and status bundle of the steed lane FIFO.
interface steed_lane_fifo_if
    import steed_lane_fifo_pkg::*;
#(
    parameter int unsigned HOST_W    = DEF_HOST_W,
    parameter int unsigned LANE_W    = DEF_LANE_W,
    parameter int unsigned NUM_LANES = DEF_NUM_LANES,
    parameter int unsigned DEPTH     = DEF_DEPTH
);
    localparam int unsigned NAND_W = NUM_LANES * LANE_W;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic              dir;
    logic              flush;
    logic              h_wr_en;
    logic [HOST_W-1:0] h_wr_data;
    logic              h_rd_en;
    logic [HOST_W-1:0] h_rd_data;
    logic              h_rd_valid;
    logic              h_ready;
    logic              n_wr_en;
    logic [NAND_W-1:0] n_wr_data;
    logic              n_rd_en;
    logic [NAND_W-1:0] n_rd_data;
    logic              n_rd_valid;
    logic              n_ready;
    logic [CNT_W-1:0]  count;
    logic              almost_full;
    logic              almost_empty;
    logic              err_clr;
    logic              err_ovf;
    logic              err_udf;
    logic              err_dir;

    modport master (
        output dir, flush, h_wr_en, h_wr_data, h_rd_en, n_wr_en, n_wr_data, n_rd_en, err_clr,
        input  h_rd_data, h_rd_valid, h_ready, n_rd_data, n_rd_valid, n_ready,
               count, almost_full, almost_empty, err_ovf, err_udf, err_dir
    );

    modport slave (
        input  dir, flush, h_wr_en, h_wr_data, h_rd_en, n_wr_en, n_wr_data, n_rd_en, err_clr,
        output h_rd_data, h_rd_valid, h_ready, n_rd_data, n_rd_valid, n_ready,
               count, almost_full, almost_empty, err_ovf, err_udf, err_dir
    );

endinterface

// File: rtl/steed_byte_ram.sv
// Byte-wide register array with PORTS contiguous write/read lanes starting at a wrapping base.
module steed_byte_ram
    import steed_lane_fifo_pkg::*;
#(
    parameter int unsigned LANE_W = DEF_LANE_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned PORTS  = 2
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [$clog2(DEPTH)-1:0]    wr_base,
    input  logic [$clog2(PORTS+1)-1:0]  wr_num,
    input  logic [PORTS*LANE_W-1:0]     wr_data,
    input  logic [$clog2(DEPTH)-1:0]    rd_base,
    output logic [PORTS*LANE_W-1:0]     rd_data_c
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned NW = $clog2(PORTS + 1);

    logic [LANE_W-1:0] mem [DEPTH];

    // Lowest lane lands at the base; DEPTH is a power of two so the index wraps for free.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                if (NW'(i) < wr_num) begin
                    mem[PW'(wr_base + PW'(i))] <= wr_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_comb begin
        rd_data_c = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            rd_data_c[i*LANE_W +: LANE_W] = mem[PW'(rd_base + PW'(i))];
        end
    end

endmodule

// File: rtl/steed_lane_fifo.sv
// Direction-switchable width-converting byte FIFO between the 16-bit host path and the NAND lanes.
module steed_lane_fifo
    import steed_lane_fifo_pkg::*;
#(
    parameter int unsigned HOST_W    = DEF_HOST_W,
    parameter int unsigned LANE_W    = DEF_LANE_W,
    parameter int unsigned NUM_LANES = DEF_NUM_LANES,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AF_THRESH = DEPTH - 4,
    parameter int unsigned AE_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst,
    steed_lane_fifo_if.slave  bus
);
    localparam int unsigned HB     = HOST_W / LANE_W;
    localparam int unsigned NB     = NUM_LANES;
    localparam int unsigned MB     = max_u(HB, NB);
    localparam int unsigned MW     = MB * LANE_W;
    localparam int unsigned NAND_W = NB * LANE_W;
    localparam int unsigned PW     = $clog2(DEPTH);
    localparam int unsigned CW     = $clog2(DEPTH + 1);
    localparam int unsigned BW     = $clog2(MB + 1);

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    dir_e              dir_q, dir_d;
    logic [HOST_W-1:0] h_rd_data_q, h_rd_data_d;
    logic [NAND_W-1:0] n_rd_data_q, n_rd_data_d;
    logic              h_rd_valid_q, h_rd_valid_d, n_rd_valid_q, n_rd_valid_d;
    logic              err_ovf_q, err_ovf_d, err_udf_q, err_udf_d, err_dir_q, err_dir_d;

    dir_e              dir_in_c;
    logic              h2n_c;
    logic [CW-1:0]     space_c;
    logic              push_req_c, pop_req_c, push_ok_c, pop_ok_c;
    logic [BW-1:0]     push_num_c, pop_num_c;
    logic [MW-1:0]     wr_data_c, ram_rd_c;
    logic              ram_we_c, ovf_set_c, udf_set_c, dir_set_c;

    // Only the side selected by the latched direction can push or pop.
    assign dir_in_c   = dir_e'(bus.dir);
    assign h2n_c      = (dir_q == DIR_H2N);
    assign space_c    = CW'(DEPTH) - count_q;
    assign push_req_c = h2n_c ? bus.h_wr_en : bus.n_wr_en;
    assign pop_req_c  = h2n_c ? bus.n_rd_en : bus.h_rd_en;
    assign push_num_c = h2n_c ? BW'(HB) : BW'(NB);
    assign pop_num_c  = h2n_c ? BW'(NB) : BW'(HB);
    assign push_ok_c  = push_req_c && (space_c >= CW'(push_num_c));
    assign pop_ok_c   = pop_req_c && (count_q >= CW'(pop_num_c));
    assign wr_data_c  = h2n_c ? MW'(bus.h_wr_data) : MW'(bus.n_wr_data);

    steed_byte_ram #(
        .LANE_W (LANE_W),
        .DEPTH  (DEPTH),
        .PORTS  (MB)
    ) u_ram (
        .clk       (clk),
        .we        (ram_we_c),
        .wr_base   (wr_ptr_q),
        .wr_num    (push_num_c),
        .wr_data   (wr_data_c),
        .rd_base   (rd_ptr_q),
        .rd_data_c (ram_rd_c)
    );

    // Next state: flush beats a direction change, which beats push/pop.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dir_d        = dir_q;
        h_rd_data_d  = h_rd_data_q;
        n_rd_data_d  = n_rd_data_q;
        h_rd_valid_d = 1'b0;
        n_rd_valid_d = 1'b0;
        ram_we_c     = 1'b0;
        ovf_set_c    = 1'b0;
        udf_set_c    = 1'b0;
        dir_set_c    = 1'b0;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (dir_in_c != dir_q) begin
            dir_d = dir_in_c;
            if (count_q != '0) begin
                wr_ptr_d  = '0;
                rd_ptr_d  = '0;
                count_d   = '0;
                dir_set_c = 1'b1;
            end
        end else begin
            if (push_req_c) begin
                if (push_ok_c) begin
                    ram_we_c = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(push_num_c);
                end else begin
                    ovf_set_c = 1'b1;
                end
            end
            if (pop_req_c) begin
                if (pop_ok_c) begin
                    rd_ptr_d = rd_ptr_q + PW'(pop_num_c);
                    if (h2n_c) begin
                        n_rd_data_d  = ram_rd_c[NAND_W-1:0];
                        n_rd_valid_d = 1'b1;
                    end else begin
                        h_rd_data_d  = ram_rd_c[HOST_W-1:0];
                        h_rd_valid_d = 1'b1;
                    end
                end else begin
                    udf_set_c = 1'b1;
                end
            end
            count_d = count_q + (push_ok_c ? CW'(push_num_c) : CW'(0))
                              - (pop_ok_c  ? CW'(pop_num_c)  : CW'(0));
        end

        // A set event in the clearing cycle keeps the flag high.
        err_ovf_d = (err_ovf_q && !bus.err_clr) || ovf_set_c;
        err_udf_d = (err_udf_q && !bus.err_clr) || udf_set_c;
        err_dir_d = (err_dir_q && !bus.err_clr) || dir_set_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dir_q        <= DIR_H2N;
            h_rd_data_q  <= '0;
            n_rd_data_q  <= '0;
            h_rd_valid_q <= 1'b0;
            n_rd_valid_q <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_udf_q    <= 1'b0;
            err_dir_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dir_q        <= dir_d;
            h_rd_data_q  <= h_rd_data_d;
            n_rd_data_q  <= n_rd_data_d;
            h_rd_valid_q <= h_rd_valid_d;
            n_rd_valid_q <= n_rd_valid_d;
            err_ovf_q    <= err_ovf_d;
            err_udf_q    <= err_udf_d;
            err_dir_q    <= err_dir_d;
        end
    end

    // Status flags decode straight from the registered count and latched direction.
    assign bus.h_rd_data    = h_rd_data_q;
    assign bus.h_rd_valid   = h_rd_valid_q;
    assign bus.n_rd_data    = n_rd_data_q;
    assign bus.n_rd_valid   = n_rd_valid_q;
    assign bus.count        = count_q;
    assign bus.h_ready      = h2n_c ? (space_c >= CW'(HB)) : (count_q >= CW'(HB));
    assign bus.n_ready      = h2n_c ? (count_q >= CW'(NB)) : (space_c >= CW'(NB));
    assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
    assign bus.err_ovf      = err_ovf_q;
    assign bus.err_udf      = err_udf_q;
    assign bus.err_dir      = err_dir_q;

endmodule

// File: tb/tb_steed_lane_fifo.sv
// Directed vector table plus randomized run against a byte-queue reference model.
module tb_steed_lane_fifo;
    import steed_lane_fifo_pkg::*;

    localparam int unsigned HOST_W = 16, LANE_W = 8, NUM_LANES = 4, DEPTH = 16;
    localparam int AF = 12, AE = 4, HB = 2, NB = 4;

    // ctl bits: {dir, flush, h_wr, n_rd, n_wr, h_rd, err_clr}
    localparam logic [6:0] C_0 = 7'b0, C_DIR = 7'b1000000, C_FL = 7'b0100000, C_HW = 7'b0010000,
                           C_NR = 7'b0001000, C_NW = 7'b0000100, C_HR = 7'b0000010, C_EC = 7'b0000001;
    // flag bits: {h_rd_valid, n_rd_valid, h_ready, n_ready, almost_full, almost_empty, err_ovf, err_udf, err_dir}
    localparam logic [8:0] F_HV = 9'h100, F_NV = 9'h080, F_HR = 9'h040, F_NR = 9'h020, F_AF = 9'h010,
                           F_AE = 9'h008, F_EO = 9'h004, F_EU = 9'h002, F_ED = 9'h001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    steed_lane_fifo_if #(.HOST_W(HOST_W), .LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .DEPTH(DEPTH)) bus ();

    steed_lane_fifo #(
        .HOST_W(HOST_W), .LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .DEPTH(DEPTH),
        .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] act_flags();
        return {bus.h_rd_valid, bus.n_rd_valid, bus.h_ready, bus.n_ready, bus.almost_full,
                bus.almost_empty, bus.err_ovf, bus.err_udf, bus.err_dir};
    endfunction

    task automatic drive(input logic [6:0] c, input logic [15:0] hwd, input logic [31:0] nwd);
        bus.dir       = c[6];
        bus.flush     = c[5];
        bus.h_wr_en   = c[4];
        bus.n_rd_en   = c[3];
        bus.n_wr_en   = c[2];
        bus.h_rd_en   = c[1];
        bus.err_clr   = c[0];
        bus.h_wr_data = hwd;
        bus.n_wr_data = nwd;
    endtask

    typedef struct {
        string       nm;
        logic [6:0]  ctl;
        logic [15:0] hwd;
        logic [31:0] nwd;
        int          cnt;
        logic [8:0]  fl;
        logic [15:0] hrd;
        logic [31:0] nrd;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(string nm, logic [6:0] ctl, logic [15:0] hwd, logic [31:0] nwd,
                                int cnt, logic [8:0] fl, logic [15:0] hrd, logic [31:0] nrd);
        vec_t v;
        v.nm = nm; v.ctl = ctl; v.hwd = hwd; v.nwd = nwd;
        v.cnt = cnt; v.fl = fl; v.hrd = hrd; v.nrd = nrd;
        vecs.push_back(v);
    endfunction

    // Reference model: a plain byte queue plus flags.
    logic [7:0]  mq[$];
    logic        m_dir, m_eo, m_eu, m_ed, m_hv, m_nv;
    logic [15:0] m_hrd;
    logic [31:0] m_nrd;

    task automatic model_reset();
        mq.delete();
        m_dir = 0; m_eo = 0; m_eu = 0; m_ed = 0; m_hv = 0; m_nv = 0;
        m_hrd = '0; m_nrd = '0;
    endtask

    task automatic model_step(input logic [6:0] c, input logic [15:0] hwd, input logic [31:0] nwd);
        int c0, pn, wn;
        bit so, su, sd, pr, wr, pok, wok;
        logic [31:0] wd, w;
        so = 0; su = 0; sd = 0;
        c0 = mq.size();
        m_hv = 0; m_nv = 0;
        if (c[5]) begin
            mq.delete();
        end else if (c[6] != m_dir) begin
            if (c0 != 0) begin mq.delete(); sd = 1; end
            m_dir = c[6];
        end else begin
            pn  = m_dir ? HB : NB;
            wn  = m_dir ? NB : HB;
            pr  = m_dir ? c[1] : c[3];
            wr  = m_dir ? c[2] : c[4];
            wd  = m_dir ? nwd : {16'h0, hwd};
            pok = pr && (c0 >= pn);
            wok = wr && ((DEPTH - c0) >= wn);
            so  = wr && !wok;
            su  = pr && !pok;
            if (pok) begin
                w = '0;
                for (int k = 0; k < pn; k++) w[8*k +: 8] = mq.pop_front();
                if (m_dir) begin m_hv = 1; m_hrd = w[15:0]; end
                else       begin m_nv = 1; m_nrd = w; end
            end
            if (wok) for (int k = 0; k < wn; k++) mq.push_back(wd[8*k +: 8]);
        end
        m_eo = (m_eo && !c[0]) || so;
        m_eu = (m_eu && !c[0]) || su;
        m_ed = (m_ed && !c[0]) || sd;
    endtask

    function automatic logic [8:0] model_flags();
        int n;
        n = mq.size();
        return {m_hv, m_nv,
                (m_dir == 0) ? ((DEPTH - n) >= HB) : (n >= HB),
                (m_dir == 0) ? (n >= NB) : ((DEPTH - n) >= NB),
                n >= AF, n <= AE, m_eo, m_eu, m_ed};
    endfunction

    initial begin
        logic [6:0] c;
        logic       cur_dir;
        int         pw;

        rst = 1'b1;
        drive(C_0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset count", bus.count, 0);
        chk("reset flags", act_flags(), F_HR | F_AE);
        chk("reset h_rd_data", bus.h_rd_data, 0);
        chk("reset n_rd_data", bus.n_rd_data, 0);
        rst = 1'b0;

        add("h2n wr0",   C_HW, 16'h2211, 0, 2, F_HR | F_AE, 0, 0);
        add("h2n wr1",   C_HW, 16'h4433, 0, 4, F_HR | F_NR | F_AE, 0, 0);
        add("h2n pop",   C_NR, 0, 0, 0, F_NV | F_HR | F_AE, 0, 32'h44332211);
        add("to n2h",    C_DIR, 0, 0, 0, F_NR | F_AE, 0, 0);
        add("n2h wr",    C_DIR | C_NW, 0, 32'hDDCCBBAA, 4, F_HR | F_NR | F_AE, 0, 0);
        add("n2h rd0",   C_DIR | C_HR, 0, 0, 2, F_HV | F_HR | F_NR | F_AE, 16'hBBAA, 0);
        add("n2h rd1",   C_DIR | C_HR, 0, 0, 0, F_HV | F_NR | F_AE, 16'hDDCC, 0);
        add("to h2n",    C_0, 0, 0, 0, F_HR | F_AE, 0, 0);
        add("fill0",     C_HW, 16'h1110, 0, 2,  F_HR | F_AE, 0, 0);
        add("fill1",     C_HW, 16'h1312, 0, 4,  F_HR | F_NR | F_AE, 0, 0);
        add("fill2",     C_HW, 16'h1514, 0, 6,  F_HR | F_NR, 0, 0);
        add("fill3",     C_HW, 16'h1716, 0, 8,  F_HR | F_NR, 0, 0);
        add("fill4",     C_HW, 16'h1918, 0, 10, F_HR | F_NR, 0, 0);
        add("fill5",     C_HW, 16'h1B1A, 0, 12, F_HR | F_NR | F_AF, 0, 0);
        add("fill6",     C_HW, 16'h1D1C, 0, 14, F_HR | F_NR | F_AF, 0, 0);
        add("fill7",     C_HW, 16'h1F1E, 0, 16, F_NR | F_AF, 0, 0);
        add("overflow",  C_HW, 16'hEEEE, 0, 16, F_NR | F_AF | F_EO, 0, 0);
        add("drain0",    C_NR, 0, 0, 12, F_NV | F_HR | F_NR | F_AF | F_EO, 0, 32'h13121110);
        add("drain1",    C_NR, 0, 0, 8,  F_NV | F_HR | F_NR | F_EO, 0, 32'h17161514);
        add("drain2",    C_NR, 0, 0, 4,  F_NV | F_HR | F_NR | F_AE | F_EO, 0, 32'h1B1A1918);
        add("drain3",    C_NR, 0, 0, 0,  F_NV | F_HR | F_AE | F_EO, 0, 32'h1F1E1D1C);
        add("wrap wr0",  C_HW, 16'h2120, 0, 2, F_HR | F_AE | F_EO, 0, 0);
        add("wrap wr1",  C_HW, 16'h2322, 0, 4, F_HR | F_NR | F_AE | F_EO, 0, 0);
        add("wrap pop",  C_NR, 0, 0, 0, F_NV | F_HR | F_AE | F_EO, 0, 32'h23222120);
        add("clr ovf",   C_EC, 0, 0, 0, F_HR | F_AE, 0, 0);
        add("udf wr",    C_HW, 16'h3130, 0, 2, F_HR | F_AE, 0, 0);
        add("underflow", C_NR, 0, 0, 2, F_HR | F_AE | F_EU, 0, 0);
        add("clr udf",   C_EC, 0, 0, 2, F_HR | F_AE, 0, 0);
        add("sim pre",   C_HW, 16'h3332, 0, 4, F_HR | F_NR | F_AE, 0, 0);
        add("sim wr+rd", C_HW | C_NR, 16'h3534, 0, 2, F_NV | F_HR | F_AE, 0, 32'h33323130);
        add("dir flush", C_DIR, 0, 0, 0, F_NR | F_AE | F_ED, 0, 0);
        add("back h2n",  C_0, 0, 0, 0, F_HR | F_AE | F_ED, 0, 0);
        add("fl pre",    C_HW, 16'h4140, 0, 2, F_HR | F_AE | F_ED, 0, 0);
        add("flush+wr",  C_FL | C_HW, 16'h4342, 0, 0, F_HR | F_AE | F_ED, 0, 0);
        add("clr+wr",    C_EC | C_HW, 16'h4544, 0, 2, F_HR | F_AE, 0, 0);
        add("post wr",   C_HW, 16'h4746, 0, 4, F_HR | F_NR | F_AE, 0, 0);
        add("post pop",  C_NR, 0, 0, 0, F_NV | F_HR | F_AE, 0, 32'h47464544);
        add("inactive",  C_NW | C_HR, 0, 32'h99887766, 0, F_HR | F_AE, 0, 0);
        add("set wins",  C_NR | C_EC, 0, 0, 0, F_HR | F_AE | F_EU, 0, 0);
        add("clr only",  C_EC, 0, 0, 0, F_HR | F_AE, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].ctl, vecs[i].hwd, vecs[i].nwd);
            @(posedge clk);
            #1;
            chk($sformatf("%s count", vecs[i].nm), bus.count, vecs[i].cnt);
            chk($sformatf("%s flags", vecs[i].nm), act_flags(), vecs[i].fl);
            if (vecs[i].fl[8]) chk($sformatf("%s h_rd_data", vecs[i].nm), bus.h_rd_data, vecs[i].hrd);
            if (vecs[i].fl[7]) chk($sformatf("%s n_rd_data", vecs[i].nm), bus.n_rd_data, vecs[i].nrd);
        end
        chk("rd_data hold", bus.n_rd_data, 32'h47464544);

        // Randomized run against the queue model.
        rst = 1'b1;
        drive(C_0, '0, '0);
        #10;
        rst = 1'b0;
        model_reset();
        cur_dir = 1'b0;
        for (int seg = 0; seg < 10; seg++) begin
            pw = $urandom_range(15, 85);
            for (int cyc = 0; cyc < 200; cyc++) begin
                if ($urandom_range(0, 149) == 0) cur_dir = ~cur_dir;
                c[6] = cur_dir;
                c[5] = ($urandom_range(0, 79) == 0);
                c[4] = ($urandom_range(0, 99) < pw);
                c[3] = ($urandom_range(0, 99) >= pw);
                c[2] = ($urandom_range(0, 99) < pw);
                c[1] = ($urandom_range(0, 99) >= pw);
                c[0] = ($urandom_range(0, 15) == 0);
                drive(c, 16'($urandom), $urandom);
                model_step(c, bus.h_wr_data, bus.n_wr_data);
                @(posedge clk);
                #1;
                chk("rand count", bus.count, mq.size());
                chk("rand flags", act_flags(), model_flags());
                chk("rand h_rd_data", bus.h_rd_data, m_hrd);
                chk("rand n_rd_data", bus.n_rd_data, m_nrd);
            end
        end

        // Asynchronous reset with data held in the FIFO.
        drive(C_0, '0, '0);
        @(posedge clk); #1;
        drive(C_FL, '0, '0);
        @(posedge clk); #1;
        drive(C_HW, 16'hA5A4, '0);
        @(posedge clk); #1;
        drive(C_HW, 16'hA7A6, '0);
        @(posedge clk); #1;
        chk("pre-reset count", bus.count, 4);
        drive(C_0, '0, '0);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset count", bus.count, 0);
        chk("async reset flags", act_flags(), F_HR | F_AE);
        chk("async reset n_rd_data", bus.n_rd_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
